// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the seven-segment scan driver.
//   SEG_0..SEG_F, SEG_OFF : segment patterns, bit order {a,b,c,d,e,f,g}, active-high.
//   ENB_OFF               : all digit enables inactive (active-low), sized for the widest display.
//   cnt_width()           : counter width for a modulus n, never below one bit.
package fnd_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1110011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam int         MAX_DIGITS = 8;
  localparam logic [7:0] ENB_OFF    = 8'hFF;

  // Width of a counter running 0..n-1; a modulus of 1 still gets one bit.
  function automatic int cnt_width(input int n);
    if (n < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fnd_hex_dec.sv
// fnd_hex_dec: combinational hex code to seven-segment decoder.
//   i_code : 4-bit hex digit code
//   o_seg  : segment pattern {a,b,c,d,e,f,g}, active-high
module fnd_hex_dec
  import fnd_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Lookup of the sixteen hex glyphs (lower-case b and d).
  always_comb begin
    case (i_code)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_disp.sv
// fnd_scan_disp: time-multiplexed seven-segment scan driver for NUM_DIGITS digits.
// New contents are loaded through a valid/ready port into a pending set and only
// copied to the active set at a frame wrap, so a frame never mixes old and new data.
//   clk, rst          : clock, asynchronous active-high reset
//   i_digits          : 4-bit code per digit, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp/i_blank/i_blink : per-digit decimal point, force-dark, blink masks
//   i_valid, o_ready  : load handshake
//   o_seg, o_seg_dp   : segments {a..g} and decimal point, active-high
//   o_seg_enb         : one-cold active-low digit enable
//   o_frame           : one-cycle pulse at each frame wrap (aligned with digit 0 output)
// Optional feature: define FND_LZB_EN for leading-zero blanking on the active set.
module fnd_scan_disp
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic [NUM_DIGITS-1:0]   i_blink,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [6:0]              o_seg,
  output logic                    o_seg_dp,
  output logic [NUM_DIGITS-1:0]   o_seg_enb,
  output logic                    o_frame
);

  localparam int PW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam int BW = cnt_width(BLINK_FRAMES);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 32'sd1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 32'sd1);
  localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_FRAMES - 32'sd1);
  localparam logic [NUM_DIGITS-1:0] ENB_ALL    = ENB_OFF[NUM_DIGITS-1:0];

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_on_q, blink_on_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d, pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                    pend_full_q, pend_full_d;
  logic                    apply_q, apply_d;
  logic                    ready_q, ready_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   seg_enb_q, seg_enb_d;
  logic                    frame_q, frame_d;

  logic                    tick_s, wrap_s, accept_s, dark_s;
  logic [3:0]              cur_code_s;
  logic [6:0]              dec_seg_s;
  logic [NUM_DIGITS-1:0]   lzb_s;

  // Scan counters, blink phase and the pending/active handshake.
  always_comb begin
    tick_s        = (presc_q == PRESC_LAST);
    wrap_s        = tick_s && (idx_q == IDX_LAST);
    accept_s      = i_valid && ready_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    act_blink_d   = act_blink_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_blink_d  = pend_blink_q;
    pend_full_d   = pend_full_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;

    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1'b1);
    end

    if (wrap_s) begin
      idx_d = '0;
    end else if (tick_s) begin
      idx_d = idx_q + IW'(1'b1);
    end else begin
      idx_d = idx_q;
    end

    if (wrap_s && (blink_cnt_q == BLINK_LAST)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else if (wrap_s) begin
      blink_cnt_d = blink_cnt_q + BW'(1'b1);
    end else begin
      blink_cnt_d = blink_cnt_q;
    end

    // Only data held in pending before this cycle is applied; a load landing on
    // the wrap cycle itself waits for the following wrap.
    if (wrap_s && pend_full_q) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      act_blink_d  = pend_blink_q;
      pend_full_d  = 1'b0;
      apply_d      = 1'b1;
    end else begin
      apply_d      = 1'b0;
    end

    if (accept_s) begin
      pend_digits_d = i_digits;
      pend_dp_d     = i_dp;
      pend_blank_d  = i_blank;
      pend_blink_d  = i_blink;
      pend_full_d   = 1'b1;
    end else begin
      pend_full_d   = pend_full_d;
    end

    // Ready returns one cycle after the apply so it trails the frame pulse.
    if (accept_s) begin
      ready_d = 1'b0;
    end else if (apply_q) begin
      ready_d = 1'b1;
    end else begin
      ready_d = ready_q;
    end
  end

`ifdef FND_LZB_EN
  logic lzb_lead_s;

  // Leading-zero mask: dark from the top digit down until a non-zero code or a lit dp.
  always_comb begin
    lzb_s      = '0;
    lzb_lead_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lzb_lead_s && (act_digits_d[4*k +: 4] == 4'h0) && !act_dp_d[k]) begin
        lzb_s[k] = 1'b1;
      end else begin
        lzb_lead_s = 1'b0;
      end
    end
  end
`else
  assign lzb_s = '0;
`endif

  assign cur_code_s = act_digits_d[{idx_d, 2'b00} +: 4];

  fnd_hex_dec u_dec (
    .i_code (cur_code_s),
    .o_seg  (dec_seg_s)
  );

  // Output stage built from next-state values so segments, enables and o_frame
  // all change on the same edge as the index.
  always_comb begin
    dark_s = act_blank_d[idx_d] | (act_blink_d[idx_d] & ~blink_on_d) | lzb_s[idx_d];
    if (dark_s) begin
      seg_d    = SEG_OFF;
      seg_dp_d = 1'b0;
    end else begin
      seg_d    = dec_seg_s;
      seg_dp_d = act_dp_d[idx_d];
    end
    seg_enb_d        = ENB_ALL;
    seg_enb_d[idx_d] = 1'b0;
    frame_d          = wrap_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_blink_q  <= '0;
      pend_full_q   <= 1'b0;
      apply_q       <= 1'b0;
      ready_q       <= 1'b1;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= 1'b0;
      seg_enb_q     <= ENB_ALL;
      frame_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      pend_full_q   <= pend_full_d;
      apply_q       <= apply_d;
      ready_q       <= ready_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      seg_enb_q     <= seg_enb_d;
      frame_q       <= frame_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = seg_dp_q;
  assign o_seg_enb = seg_enb_q;
  assign o_frame   = frame_q;

endmodule
